unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between the fetch stage and the load/store stage of the RV32I core.
- Grants one requester at a time and drives a multi-cycle request/ack handshake toward memory.
- Returns read data and a one-cycle ready pulse to the winning requester.
- Data accesses have priority. A streak limit prevents fetch starvation.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- MAX_D_STREAK, 4, number of consecutive data grants allowed while a fetch is pending before fetch is forced (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- if_req  in  1  fetch request. Level; held until if_ready.
- if_addr  in  AW  fetch byte address. Stable while if_req=1.
- if_rdata  out  DW  fetched word. Valid only when if_ready=1.
- if_ready  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request. Level; held until d_ready.
- d_we  in  1  1=store, 0=load.
- d_addr  in  AW  data byte address.
- d_wdata  in  DW  store data.
- d_be  in  DW/8  byte enables for stores.
- d_rdata  out  DW  load data. Valid only when d_ready=1.
- d_ready  out  1  one-cycle completion pulse for data.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  registered write enable.
- mem_addr  out  AW  registered address.
- mem_wdata  out  DW  registered write data.
- mem_be  out  DW/8  registered byte enables. All ones for fetch.
- mem_rdata  in  DW  memory read data. Valid with mem_ack.
- mem_ack  in  1  memory completion, one-cycle pulse.
- owner_d  out  1  1 while the current or last grant is data.
- busy  out  1  1 when state is not IDLE.

Behaviour:
- Reset (synchronous): state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, owner_d=0, streak=0, busy=0. Ready outputs are 0.
- States are IDLE, BUSY_IF and BUSY_D.
- IDLE, grant decision at rising edge t:
  - force_if = if_req & (streak == MAX_D_STREAK).
  - If d_req & ~force_if: latch d_addr/d_we/d_wdata/d_be into mem_*; mem_req=1; owner_d=1; go to BUSY_D.
  - Else if if_req: latch if_addr, mem_we=0, mem_be=all ones, mem_wdata=0; mem_req=1; owner_d=0; go to BUSY_IF.
  - Else stay in IDLE with mem_req=0.
- Streak counter, updated on grant only:
  - Data grant with if_req=1: streak = min(streak+1, MAX_D_STREAK).
  - Data grant with if_req=0: streak=0.
  - Fetch grant: streak=0.
- BUSY_x:
  - mem_req and all mem_* outputs are held stable until mem_ack.
  - On mem_ack=1, ready for the owner is asserted combinationally in the same cycle: if_ready = mem_ack & (state==BUSY_IF); d_ready = mem_ack & (state==BUSY_D).
  - On the same cycle, rdata for the owner = mem_rdata. Rdata of the non-owner is 0.
  - Next edge: mem_req=0, state=IDLE.
- Latency:
  - Request high at edge t gives mem_req=1 from t+1.
  - Minimum requester-visible latency = 1 + memory latency.
  - The arbiter idles one cycle between back-to-back grants because mem_req drops in IDLE.
- Requester rule: a requester samples ready at the edge and deasserts or changes req before the next edge. The arbiter does not filter a stale req.
- mem_ack in IDLE is ignored: no ready, no state change.
- Requests arriving while BUSY are not granted until IDLE. The requester holds req.
- A change to the owner's address or data while BUSY is ignored; latched values are used.
- rst mid-transaction:
  - The transaction is abandoned and no ready is issued.
  - mem_req=0 next edge.
  - The memory side must drop the abandoned access on rst.
- owner_d holds its value in IDLE. busy = (state != IDLE).
- No combinational path from if_req/d_req to mem_*. The only combinational paths are mem_ack→ready and mem_rdata→rdata.

Test Plan:
- Reset then single fetch: if_req=1, if_addr=0x10, memory ack after 2 cycles with rdata=0x00500093. Required: mem_req rises 1 cycle after req with mem_addr=0x10 and mem_be=0xF; if_ready pulses 1 cycle with if_rdata=0x00500093; mem_req=0 next cycle.
- Simultaneous if_req and d_req (load 0x80) in IDLE with streak=0. Required: data granted first (mem_addr=0x80, owner_d=1), then fetch granted after d_ready plus one IDLE cycle.
- Starvation guard, MAX_D_STREAK=4: hold if_req=1 and issue 6 back-to-back stores. Required: grants are D,D,D,D,IF,D,D; streak is 0 after the IF grant.
- Store 0xDEADBEEF, d_be=0x3, to 0x84. Required: mem_we=1, mem_wdata=0xDEADBEEF, mem_be=0x3, all held stable through a 5-cycle ack delay; d_ready pulses once; d_rdata=0.
- rst asserted one cycle after a fetch grant, before ack. Required: no if_ready; state IDLE, mem_req=0 and streak=0 after the rst edge. A spurious mem_ack in IDLE produces no ready.
- Addr change: change d_addr from 0x80 to 0x90 mid-BUSY_D. Required: mem_addr stays 0x80 until ack.

Source files
------------

// File: rtl/unified_mem_arbiter_if.sv
// Fetch / load-store / memory bundle for the unified memory arbiter.
// slave is the arbiter side; master is the core plus memory side.
interface unified_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic [DW-1:0]   if_rdata;
  logic            if_ready;
  logic            d_req;
  logic            d_we;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic [DW/8-1:0] d_be;
  logic [DW-1:0]   d_rdata;
  logic            d_ready;
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_be;
  logic [DW-1:0]   mem_rdata;
  logic            mem_ack;
  logic            owner_d;
  logic            busy;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr,
    input  d_wdata, d_be,
    input  mem_rdata, mem_ack,
    output if_rdata, if_ready,
    output d_rdata, d_ready,
    output mem_req, mem_we,
    output mem_addr, mem_wdata,
    output mem_be,
    output owner_d, busy
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr,
    output d_wdata, d_be,
    output mem_rdata, mem_ack,
    input  if_rdata, if_ready,
    input  d_rdata, d_ready,
    input  mem_req, mem_we,
    input  mem_addr, mem_wdata,
    input  mem_be,
    input  owner_d, busy
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Single-port memory arbiter: data first, fetch
// forced after MAX_D_STREAK data grants.
module unified_mem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_D_STREAK = 4
) (
  input logic clk,
  input logic rst,
  unified_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;

  localparam int BW = DW / 8;
  localparam logic [3:0] STREAK_MAX =
    4'(MAX_D_STREAK);

  state_t          state_q, state_d;
  logic [3:0]      streak_q, streak_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [BW-1:0]   be_q, be_d;
  logic            own_q, own_d;
  logic            force_if;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      streak_q <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      own_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      own_q    <= own_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    own_d    = own_q;
    force_if = bus.if_req &&
               (streak_q == STREAK_MAX);
    unique case (state_q)
      IDLE: begin
        req_d = 1'b0;
        if (bus.d_req && !force_if) begin
          state_d = BUSY_D;
          req_d   = 1'b1;
          we_d    = bus.d_we;
          addr_d  = bus.d_addr;
          wdata_d = bus.d_wdata;
          be_d    = bus.d_be;
          own_d   = 1'b1;
          // streak only grows while fetch waits
          if (!bus.if_req)
            streak_d = '0;
          else if (streak_q != STREAK_MAX)
            streak_d = streak_q + 4'd1;
        end else if (bus.if_req) begin
          state_d  = BUSY_IF;
          req_d    = 1'b1;
          we_d     = 1'b0;
          addr_d   = bus.if_addr;
          wdata_d  = '0;
          be_d     = '1;
          own_d    = 1'b0;
          streak_d = '0;
        end
      end
      BUSY_IF, BUSY_D: begin
        if (bus.mem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  assign bus.if_ready = bus.mem_ack &&
                        (state_q == BUSY_IF);
  assign bus.d_ready  = bus.mem_ack &&
                        (state_q == BUSY_D);
  assign bus.if_rdata = bus.if_ready ?
                        bus.mem_rdata : '0;
  assign bus.d_rdata  = bus.d_ready ?
                        bus.mem_rdata : '0;

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;
  assign bus.owner_d   = own_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: a queue-based
// reference model predicts grants and ready pulses.
module tb_unified_mem_arbiter;
  localparam int MAXS = 4;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dop_t;
  typedef struct {
    int   cyc;
    bit   is_d;
    dop_t op;
  } grant_t;
  typedef struct {
    int          cyc;
    bit          is_d;
    logic [31:0] rdata;
  } rdy_t;
  typedef struct {
    bit busy;
    bit own;
    bit rchk;
  } cyc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.AW(32), .DW(32)) bus();

  unified_mem_arbiter #(
    .AW(32), .DW(32), .MAX_D_STREAK(MAXS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 0;

  grant_t exp_grant[$];
  rdy_t   exp_rdy[$];
  cyc_t   exp_cyc[$];

  logic [31:0] mem_arr[64];
  logic [31:0] ref_arr[64];

  // reference model state
  int     m_st = 0;
  int     m_streak = 0;
  int     m_wait = 0;
  bit     m_own = 0;
  bit     after_rst = 0;
  grant_t m_g;

  // requesters
  logic [31:0] fq[$];
  dop_t        dq[$];
  bit          f_act = 0, d_act = 0;
  bit          f_done = 0, d_done = 0;
  logic [31:0] f_addr = '0;
  dop_t        dcur;
  int          lat_fix = -1;
  bit          jitter = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h cyc %0d",
               nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s cyc %0d", nm, cyc);
  endtask

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic cycle(input bit do_rst,
                       input bit spur);
    bit   acked;
    bit   frc;
    rdy_t rr;
    cyc_t cc;
    @(posedge clk);
    #1;
    cyc++;
    if (f_done) f_act = 0;
    if (d_done) d_act = 0;
    f_done = 0;
    d_done = 0;
    if (do_rst) begin
      f_act = 0;
      d_act = 0;
    end else begin
      if (!f_act && fq.size() > 0) begin
        f_act  = 1;
        f_addr = fq.pop_front();
      end
      if (!d_act && dq.size() > 0) begin
        d_act = 1;
        dcur  = dq.pop_front();
      end
    end
    if (jitter && m_st == 2 && d_act) begin
      dcur.addr  = dcur.addr | 32'h10;
      dcur.wdata = $urandom;
    end
    rst         = do_rst;
    bus.if_req  = f_act;
    bus.if_addr = f_addr;
    bus.d_req   = d_act;
    bus.d_we    = dcur.we;
    bus.d_addr  = dcur.addr;
    bus.d_wdata = dcur.wdata;
    bus.d_be    = dcur.be;

    // memory side and expected ready
    acked = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = $urandom;
    if (!do_rst && m_st != 0) begin
      if (m_wait == 0) begin
        acked = 1;
        bus.mem_ack = 1'b1;
        if (bus.mem_we) begin
          mem_arr[bus.mem_addr[7:2]] =
            merge(mem_arr[bus.mem_addr[7:2]],
                  bus.mem_wdata, bus.mem_be);
          bus.mem_rdata = '0;
        end else begin
          bus.mem_rdata = mem_arr[bus.mem_addr[7:2]];
        end
        rr.cyc  = cyc;
        rr.is_d = (m_st == 2);
        if (m_g.op.we) begin
          ref_arr[m_g.op.addr[7:2]] =
            merge(ref_arr[m_g.op.addr[7:2]],
                  m_g.op.wdata, m_g.op.be);
          rr.rdata = '0;
        end else begin
          rr.rdata = ref_arr[m_g.op.addr[7:2]];
        end
        exp_rdy.push_back(rr);
        if (m_st == 1) f_done = 1;
        else           d_done = 1;
      end else begin
        m_wait--;
      end
    end else if (spur && m_st == 0) begin
      bus.mem_ack = 1'b1;
    end

    if (mon_en) begin
      cc.busy = (m_st != 0);
      cc.own  = m_own;
      cc.rchk = after_rst;
      exp_cyc.push_back(cc);
    end

    // model of the coming clock edge
    if (do_rst) begin
      m_st = 0;
      m_streak = 0;
      m_own = 0;
      after_rst = 1;
    end else begin
      after_rst = 0;
      if (m_st != 0) begin
        if (acked) m_st = 0;
      end else begin
        frc = f_act && (m_streak == MAXS);
        if (d_act && !frc) begin
          m_st = 2;
          m_own = 1;
          m_g.is_d = 1;
          m_g.op = dcur;
          m_streak = f_act ?
            ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
        end else if (f_act) begin
          m_st = 1;
          m_own = 0;
          m_g.is_d = 0;
          m_g.op = '{we: 1'b0, addr: f_addr,
                     wdata: 32'h0, be: 4'hF};
          m_streak = 0;
        end
        if (m_st != 0) begin
          m_g.cyc = cyc + 1;
          exp_grant.push_back(m_g);
          m_wait = (lat_fix >= 0) ? lat_fix :
                   int'($urandom_range(0, 4));
        end
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_st != 0 || f_act || d_act ||
            fq.size() > 0 || dq.size() > 0) &&
           n < 400) begin
      cycle(0, 0);
      n++;
    end
    chk("drain_timeout", 32'(n < 400), 32'd1);
    cycle(0, 0);
    cycle(0, 0);
  endtask

  // monitor
  cyc_t   mon_c;
  grant_t mon_g;
  grant_t cur;
  rdy_t   mon_r;
  logic   prev_req = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_cyc.size() > 0) begin
        mon_c = exp_cyc.pop_front();
        chk("busy", 32'(bus.busy), 32'(mon_c.busy));
        chk("mem_req", 32'(bus.mem_req),
            32'(mon_c.busy));
        chk("owner_d", 32'(bus.owner_d),
            32'(mon_c.own));
        if (mon_c.rchk) begin
          chk("rst_addr", bus.mem_addr, 32'h0);
          chk("rst_we", 32'(bus.mem_we), 32'h0);
          chk("rst_wdata", bus.mem_wdata, 32'h0);
          chk("rst_be", 32'(bus.mem_be), 32'h0);
        end
      end
      if (bus.mem_req === 1'b1 && !prev_req) begin
        if (exp_grant.size() == 0) begin
          fail("unexpected_grant");
        end else begin
          mon_g = exp_grant.pop_front();
          chk("grant_cyc", 32'(cyc), 32'(mon_g.cyc));
          chk("grant_owner", 32'(bus.owner_d),
              32'(mon_g.is_d));
          chk("grant_addr", bus.mem_addr,
              mon_g.op.addr);
          chk("grant_we", 32'(bus.mem_we),
              32'(mon_g.op.we));
          chk("grant_wdata", bus.mem_wdata,
              mon_g.op.wdata);
          chk("grant_be", 32'(bus.mem_be),
              32'(mon_g.op.be));
          cur = mon_g;
        end
      end else if (bus.mem_req === 1'b1) begin
        chk("hold_addr", bus.mem_addr, cur.op.addr);
        chk("hold_we", 32'(bus.mem_we),
            32'(cur.op.we));
        chk("hold_wdata", bus.mem_wdata,
            cur.op.wdata);
        chk("hold_be", 32'(bus.mem_be),
            32'(cur.op.be));
      end
      prev_req = bus.mem_req;
      if (bus.if_ready === 1'b1 ||
          bus.d_ready === 1'b1) begin
        if (exp_rdy.size() == 0) begin
          fail("unexpected_ready");
        end else begin
          mon_r = exp_rdy.pop_front();
          chk("ready_cyc", 32'(cyc), 32'(mon_r.cyc));
          chk("if_ready", 32'(bus.if_ready),
              32'(!mon_r.is_d));
          chk("d_ready", 32'(bus.d_ready),
              32'(mon_r.is_d));
          if (mon_r.is_d) begin
            chk("d_rdata", bus.d_rdata, mon_r.rdata);
            chk("if_rdata_zero", bus.if_rdata, 32'h0);
          end else begin
            chk("if_rdata", bus.if_rdata, mon_r.rdata);
            chk("d_rdata_zero", bus.d_rdata, 32'h0);
          end
        end
      end else if (exp_rdy.size() > 0 &&
                   exp_rdy[0].cyc <= cyc) begin
        fail("missing_ready");
        void'(exp_rdy.pop_front());
      end
    end
  end

  initial begin
    int   k;
    dop_t op;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.d_be      = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    dcur = '{we: 1'b0, addr: 32'h0,
             wdata: 32'h0, be: 4'h0};
    for (int i = 0; i < 64; i++) begin
      mem_arr[i] = $urandom;
      ref_arr[i] = mem_arr[i];
    end
    mem_arr[4] = 32'h00500093;
    ref_arr[4] = 32'h00500093;

    cycle(1, 0);
    cycle(1, 0);
    mon_en = 1;
    cycle(0, 0);

    // single fetch, ack two cycles into the access
    lat_fix = 1;
    fq.push_back(32'h10);
    drain();

    // simultaneous fetch and load: data wins
    lat_fix = 2;
    fq.push_back(32'h20);
    dq.push_back('{we: 1'b0, addr: 32'h80,
                   wdata: 32'h0, be: 4'hF});
    drain();

    // starvation guard: fetch held, six stores
    lat_fix = 0;
    fq.push_back(32'h30);
    for (int i = 0; i < 6; i++)
      dq.push_back('{we: 1'b1,
                     addr: 32'(i) << 2 | 32'h40,
                     wdata: $urandom, be: 4'hF});
    drain();

    // partial store held through a long ack delay
    lat_fix = 5;
    dq.push_back('{we: 1'b1, addr: 32'h84,
                   wdata: 32'hDEADBEEF, be: 4'h3});
    drain();

    // reset one cycle after a fetch grant
    lat_fix = 10;
    fq.push_back(32'h40);
    k = 0;
    while (m_st == 0 && k < 20) begin
      cycle(0, 0);
      k++;
    end
    cycle(0, 0);
    cycle(1, 0);
    cycle(0, 1);
    cycle(0, 1);
    drain();

    // owner changes its address mid-access
    jitter = 1;
    lat_fix = 4;
    dq.push_back('{we: 1'b0, addr: 32'h80,
                   wdata: 32'h0, be: 4'hF});
    drain();

    // randomized traffic
    lat_fix = -1;
    for (int i = 0; i < 1500; i++) begin
      if (fq.size() == 0 &&
          $urandom_range(0, 2) == 0)
        fq.push_back(32'($urandom_range(0, 63)) << 2);
      if (dq.size() == 0 &&
          $urandom_range(0, 1) == 0) begin
        op.we    = 1'($urandom_range(0, 1));
        op.addr  = 32'($urandom_range(0, 63)) << 2;
        op.wdata = $urandom;
        op.be    = 4'($urandom_range(1, 15));
        dq.push_back(op);
      end
      cycle($urandom_range(0, 199) == 0,
            $urandom_range(0, 5) == 0);
    end
    fq.delete();
    dq.delete();
    drain();
    jitter = 0;

    chk("grants_left", 32'(exp_grant.size()), 32'd0);
    chk("readies_left", 32'(exp_rdy.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
